// File: rtl/uart_cmd_engine.sv
// Host command engine: parses UART command frames into core config, overlay, text and ROM streams.
// Optional `ROM_CHECKSUM_EN adds a trailing mod-256 checksum byte to CMD7 plus a reply and error pulse.
module uart_cmd_engine #(
    parameter int unsigned CORE_ID   = 1,
    parameter int unsigned CFG_BYTES = 4,
    parameter int unsigned LEN_BYTES = 3,
    parameter int unsigned COLS      = 32,
    parameter int unsigned ROWS      = 28,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [8*CFG_BYTES-1:0] core_config,
    output logic                   overlay,
    output logic [7:0]             cursor_x,
    output logic [7:0]             cursor_y,
    output logic [7:0]             x_wr,
    output logic [7:0]             y_wr,
    output logic [7:0]             char_wr,
    output logic                   we,
    output logic [7:0]             rom_loading,
    output logic [7:0]             rom_do,
    output logic                   rom_do_valid,
    output logic [8*LEN_BYTES-1:0] rom_remain,
`ifdef ROM_CHECKSUM_EN
    output logic                   rom_csum_err,
`endif
    output logic                   busy
);
    localparam int unsigned CW = 8 * CFG_BYTES;
    localparam int unsigned LW = 8 * LEN_BYTES;
    localparam logic [3:0]  CfgLast   = 4'(CFG_BYTES - 1);
    localparam logic [3:0]  LenLast   = 4'(LEN_BYTES - 1);
    localparam logic [3:0]  RespLen   = 4'(CFG_BYTES + 3);
    localparam logic [7:0]  XMax      = 8'(COLS - 1);
    localparam logic [7:0]  YMax      = 8'(ROWS - 1);
    localparam logic [7:0]  CoreIdB   = 8'(CORE_ID);
    localparam logic [7:0]  CfgBytesB = 8'(CFG_BYTES);
    localparam logic [31:0] TmoLast   = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle, StArg, StStr, StRomLen, StRomData, StRomCsum, StResp
    } state_e;

    state_e          r_state;
    logic [7:0]      r_cmd;
    logic [3:0]      r_cnt;
    logic [3:0]      r_resp_len;
    logic [CW-1:0]   r_cfg_acc;
    logic [LW-1:0]   r_len_acc;
    logic [7:0]      r_arg_x;
    logic [31:0]     r_tmo;
`ifdef ROM_CHECKSUM_EN
    logic [7:0]      r_csum;
`endif

    logic [CW+7:0]   w_cfg_cat;
    logic [LW+7:0]   w_len_cat;
    logic [CW-1:0]   w_cfg_next;
    logic [LW-1:0]   w_len_next;
    logic [7:0]      w_clamp_x;
    logic [7:0]      w_clamp_y;
    logic            w_timed;
    logic            w_expire;
    logic [7:0]      w_resp_byte;

    // Multi-byte args arrive LSB first: shift each new byte in at the top.
    assign w_cfg_cat  = {rx_data, r_cfg_acc};
    assign w_len_cat  = {rx_data, r_len_acc};
    assign w_cfg_next = w_cfg_cat[CW+7:8];
    assign w_len_next = w_len_cat[LW+7:8];
    assign w_clamp_x  = ({24'd0, rx_data} >= COLS) ? XMax : rx_data;
    assign w_clamp_y  = ({24'd0, rx_data} >= ROWS) ? YMax : rx_data;
    assign w_timed    = (r_state != StIdle) && (r_state != StResp);
    assign w_expire   = w_timed && !rx_valid && (TIMEOUT != 0) && (r_tmo == TmoLast);
    assign busy       = (r_state != StIdle);

    // CMD1 reply byte for index r_cnt; index 0 (CORE_ID) is loaded when the command is decoded.
    always_comb begin
        w_resp_byte = 8'h00;
        if (r_cnt == 4'd1) w_resp_byte = CfgBytesB;
        for (int i = 0; i < int'(CFG_BYTES); i++) begin
            if (r_cnt == 4'(i + 2)) w_resp_byte = core_config[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= StIdle;
            r_cmd        <= '0;
            r_cnt        <= '0;
            r_resp_len   <= '0;
            r_cfg_acc    <= '0;
            r_len_acc    <= '0;
            r_arg_x      <= '0;
            r_tmo        <= '0;
            tx_data      <= '0;
            tx_valid     <= 1'b0;
            core_config  <= '0;
            overlay      <= 1'b0;
            cursor_x     <= '0;
            cursor_y     <= '0;
            x_wr         <= '0;
            y_wr         <= '0;
            char_wr      <= '0;
            we           <= 1'b0;
            rom_loading  <= '0;
            rom_do       <= '0;
            rom_do_valid <= 1'b0;
            rom_remain   <= '0;
`ifdef ROM_CHECKSUM_EN
            r_csum       <= '0;
            rom_csum_err <= 1'b0;
`endif
        end else begin
            we           <= 1'b0;
            rom_do_valid <= 1'b0;
`ifdef ROM_CHECKSUM_EN
            rom_csum_err <= 1'b0;
`endif
            if (w_timed) r_tmo <= rx_valid ? '0 : r_tmo + 32'd1;

            if (w_expire) begin
                r_state    <= StIdle;
                rom_remain <= '0;
            end else begin
                case (r_state)
                    StIdle: if (rx_valid) begin
                        r_cmd <= rx_data;
                        r_cnt <= '0;
                        r_tmo <= '0;
`ifdef ROM_CHECKSUM_EN
                        r_csum <= '0;
`endif
                        case (rx_data)
                            8'd1: begin
                                tx_data    <= CoreIdB;
                                tx_valid   <= 1'b1;
                                r_cnt      <= 4'd1;
                                r_resp_len <= RespLen;
                                r_state    <= StResp;
                            end
                            8'd2, 8'd3, 8'd4, 8'd6: r_state <= StArg;
                            8'd5:    r_state <= StStr;
                            8'd7:    r_state <= StRomLen;
                            default: ;
                        endcase
                    end
                    StArg: if (rx_valid) begin
                        r_cnt <= r_cnt + 4'd1;
                        case (r_cmd)
                            8'd2: begin
                                r_cfg_acc <= w_cfg_next;
                                if (r_cnt == CfgLast) begin
                                    core_config <= w_cfg_next;
                                    r_state     <= StIdle;
                                end
                            end
                            8'd3: begin
                                overlay <= rx_data[0];
                                r_state <= StIdle;
                            end
                            8'd4: begin
                                if (r_cnt == 4'd0) begin
                                    r_arg_x <= w_clamp_x;
                                end else begin
                                    cursor_x <= r_arg_x;
                                    cursor_y <= w_clamp_y;
                                    r_state  <= StIdle;
                                end
                            end
                            8'd6: begin
                                rom_loading <= rx_data;
                                r_state     <= StIdle;
                            end
                            default: r_state <= StIdle;
                        endcase
                    end
                    StStr: if (rx_valid) begin
                        if (rx_data == 8'd0) begin
                            r_state <= StIdle;
                        end else begin
                            we      <= 1'b1;
                            x_wr    <= cursor_x;
                            y_wr    <= cursor_y;
                            char_wr <= rx_data;
                            if (cursor_x == XMax) begin
                                cursor_x <= '0;
                                cursor_y <= (cursor_y == YMax) ? 8'd0 : cursor_y + 8'd1;
                            end else begin
                                cursor_x <= cursor_x + 8'd1;
                            end
                        end
                    end
                    StRomLen: if (rx_valid) begin
                        r_len_acc <= w_len_next;
                        r_cnt     <= r_cnt + 4'd1;
                        if (r_cnt == LenLast) begin
                            if (w_len_next == '0) begin
`ifdef ROM_CHECKSUM_EN
                                r_state <= StRomCsum;
`else
                                r_state <= StIdle;
`endif
                            end else begin
                                rom_remain <= w_len_next;
                                r_state    <= StRomData;
                            end
                        end
                    end
                    StRomData: if (rx_valid) begin
                        rom_do       <= rx_data;
                        rom_do_valid <= 1'b1;
                        rom_remain   <= rom_remain - LW'(1);
`ifdef ROM_CHECKSUM_EN
                        r_csum <= r_csum + rx_data;
                        if (rom_remain == LW'(1)) r_state <= StRomCsum;
`else
                        if (rom_remain == LW'(1)) r_state <= StIdle;
`endif
                    end
`ifdef ROM_CHECKSUM_EN
                    StRomCsum: if (rx_valid) begin
                        tx_data      <= (rx_data == r_csum) ? 8'h00 : 8'hFF;
                        tx_valid     <= 1'b1;
                        rom_csum_err <= (rx_data != r_csum);
                        r_cnt        <= 4'd1;
                        r_resp_len   <= 4'd1;
                        r_state      <= StResp;
                    end
`endif
                    StResp: if (tx_valid && tx_ready) begin
                        if (r_cnt == r_resp_len) begin
                            tx_valid <= 1'b0;
                            r_state  <= StIdle;
                        end else begin
                            tx_data <= w_resp_byte;
                            r_cnt   <= r_cnt + 4'd1;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_engine.sv
// Scoreboard bench for uart_cmd_engine: expected tx bytes, char writes and ROM bytes are queued
// as stimulus is driven and checked by negedge monitors.
module tb_uart_cmd_engine;
    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] core_config;
    logic        overlay;
    logic [7:0]  cursor_x, cursor_y, x_wr, y_wr, char_wr, rom_loading, rom_do;
    logic        we, rom_do_valid, busy;
    logic [23:0] rom_remain;
`ifdef ROM_CHECKSUM_EN
    logic        rom_csum_err;
    int          csum_err_cnt = 0;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [7:0]  tx_q[$];
    logic [7:0]  rom_q[$];
    logic [23:0] wr_q[$];

    always #5 clk = ~clk;

    uart_cmd_engine #(.TIMEOUT(40)) dut (
        .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .core_config(core_config), .overlay(overlay), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .x_wr(x_wr), .y_wr(y_wr), .char_wr(char_wr), .we(we), .rom_loading(rom_loading),
        .rom_do(rom_do), .rom_do_valid(rom_do_valid), .rom_remain(rom_remain),
`ifdef ROM_CHECKSUM_EN
        .rom_csum_err(rom_csum_err),
`endif
        .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Unexpected outputs are compared against an out-of-range marker so they always miscompare.
    always @(negedge clk) begin
        if (resetn && tx_valid && tx_ready) begin
            if (tx_q.size() > 0) check("tx_byte", {1'b0, tx_data}, {1'b0, tx_q.pop_front()});
            else                 check("tx_byte", {1'b0, tx_data}, 9'h100);
        end
        if (resetn && we) begin
            if (wr_q.size() > 0) check("char_wr", {1'b0, x_wr, y_wr, char_wr}, {1'b0, wr_q.pop_front()});
            else                 check("char_wr", {1'b0, x_wr, y_wr, char_wr}, 25'h1000000);
        end
        if (resetn && rom_do_valid) begin
            if (rom_q.size() > 0) check("rom_do", {1'b0, rom_do}, {1'b0, rom_q.pop_front()});
            else                  check("rom_do", {1'b0, rom_do}, 9'h100);
        end
`ifdef ROM_CHECKSUM_EN
        if (resetn && rom_csum_err) csum_err_cnt++;
`endif
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1 rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic push_cmd1(input logic [31:0] cfg);
        tx_q.push_back(8'h01);
        tx_q.push_back(8'h04);
        for (int i = 0; i < 4; i++) tx_q.push_back(cfg[8*i +: 8]);
        tx_q.push_back(8'h00);
    endtask

    initial begin
        resetn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        idle(3);
        check("rst_cfg", core_config, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_txv", tx_valid, 1'b0);
        check("rst_cursor", {cursor_x, cursor_y}, 16'h0);
        check("rst_remain", rom_remain, 24'h0);
        resetn = 1'b1;
        idle(2);

        // CMD1 with a mid-frame back-pressure stall.
        push_cmd1(32'h0);
        send(8'h01);
        tx_ready = 1'b0;
        idle(10);
        check("cmd1_stall_busy", busy, 1'b1);
        tx_ready = 1'b1;
        wait_idle("cmd1_done");
        idle(2);
        check("cmd1_q", tx_q.size(), 0);

        // CMD2: config commits only after the final byte.
        send(8'h02); send(8'hA5); send(8'h5A); send(8'h3C);
        check("cfg_partial", core_config, 32'h0);
        send(8'hC3);
        check("cfg_full", core_config, 32'hC33C5AA5);
        send(8'h03); send(8'h01);
        check("overlay_on", overlay, 1'b1);

        push_cmd1(32'hC33C5AA5);
        send(8'h01);
        wait_idle("cmd1b_done");
        idle(2);
        check("cmd1b_q", tx_q.size(), 0);

        // Cursor and string writes with x wrap.
        send(8'h04); send(8'h1F); send(8'h01);
        check("cursor_set", {cursor_x, cursor_y}, 16'h1F01);
        wr_q.push_back({8'h1F, 8'h01, 8'h43});
        wr_q.push_back({8'h00, 8'h02, 8'h44});
        send(8'h05); send(8'h43); send(8'h44); send(8'h00);
        check("cursor_after_str", {cursor_x, cursor_y}, 16'h0102);
        check("str_busy", busy, 1'b0);
        send(8'h04); send(8'hFF); send(8'hFF);
        check("cursor_clamp", {cursor_x, cursor_y}, 16'h1F1B);
        wr_q.push_back({8'h1F, 8'h1B, 8'h45});
        send(8'h05); send(8'h45); send(8'h00);
        check("cursor_ywrap", {cursor_x, cursor_y}, 16'h0000);
        idle(2);
        check("wr_q", wr_q.size(), 0);

        send(8'h06); send(8'h5A);
        check("rom_loading", rom_loading, 8'h5A);

        // CMD7 with three data bytes.
        send(8'h07); send(8'h03); send(8'h00); send(8'h00);
        check("rom_len", rom_remain, 24'h3);
        rom_q.push_back(8'h11); rom_q.push_back(8'h22); rom_q.push_back(8'h33);
        send(8'h11); send(8'h22); send(8'h33);
        check("rom_remain0", rom_remain, 24'h0);
`ifdef ROM_CHECKSUM_EN
        tx_q.push_back(8'h00);
        send(8'h66);
        wait_idle("rom_csum_done");
`else
        check("rom_busy", busy, 1'b0);
`endif
        idle(2);
        check("rom_q", rom_q.size(), 0);

        // Zero length skips the data phase.
        send(8'h07); send(8'h00); send(8'h00); send(8'h00);
`ifdef ROM_CHECKSUM_EN
        check("len0_busy", busy, 1'b1);
        tx_q.push_back(8'h00);
        send(8'h00);
        wait_idle("len0_done");
`else
        check("len0_busy", busy, 1'b0);
`endif

        // Timeout during CMD2 discards partial arguments.
        send(8'h02); send(8'h11); send(8'h22);
        idle(60);
        check("tmo_busy", busy, 1'b0);
        check("tmo_cfg", core_config, 32'hC33C5AA5);
        send(8'h03); send(8'h00);
        check("tmo_overlay", overlay, 1'b0);

        // Timeout during ROM data clears rom_remain.
        send(8'h07); send(8'h05); send(8'h00); send(8'h00);
        rom_q.push_back(8'h77);
        send(8'h77);
        check("rom_mid", rom_remain, 24'h4);
        idle(60);
        check("rom_tmo_remain", rom_remain, 24'h0);
        check("rom_tmo_busy", busy, 1'b0);

        send(8'h00);
        check("zero_ignored", busy, 1'b0);
        send(8'h09);
        check("unknown_dropped", busy, 1'b0);

        // Bytes received during RESP are dropped.
        tx_ready = 1'b0;
        push_cmd1(32'hC33C5AA5);
        send(8'h01); send(8'h03); send(8'h01);
        tx_ready = 1'b1;
        wait_idle("resp_drop_done");
        idle(3);
        check("resp_drop_busy", busy, 1'b0);
        check("resp_drop_overlay", overlay, 1'b0);
        check("resp_drop_q", tx_q.size(), 0);

`ifdef ROM_CHECKSUM_EN
        send(8'h07); send(8'h02); send(8'h00); send(8'h00);
        rom_q.push_back(8'h10); rom_q.push_back(8'h20);
        send(8'h10); send(8'h20);
        tx_q.push_back(8'h00);
        send(8'h30);
        wait_idle("csum_ok_done");
        send(8'h07); send(8'h02); send(8'h00); send(8'h00);
        rom_q.push_back(8'h10); rom_q.push_back(8'h20);
        send(8'h10); send(8'h20);
        tx_q.push_back(8'hFF);
        send(8'h31);
        wait_idle("csum_bad_done");
        idle(2);
        check("csum_err_pulses", csum_err_cnt, 1);
        check("csum_q", tx_q.size(), 0);
`endif

        // Reset while a reply byte is pending.
        tx_ready = 1'b0;
        send(8'h01);
        check("pend_txv", tx_valid, 1'b1);
        resetn = 1'b0;
        idle(1);
        check("mid_rst_txv", tx_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_cfg", core_config, 32'h0);
        resetn = 1'b1;
        tx_ready = 1'b1;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
